soc1_nios_oci_dct_packer: RTL and testbench

//  Upstream feeder of the OCI trace test bench. Packs 2-bit data-capture-trace
//    (DCT) atoms from the OCI trace unit into a 30-bit shift buffer with an atom count.

---
 rtl/soc1_nios_oci_dct_packer.sv | 71 +++++++
 tb/tb_soc1_nios_oci_dct_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/soc1_nios_oci_dct_packer.sv
// soc1_nios_oci_dct_packer: packs 2-bit DCT trace atoms into 30-bit words, hands them downstream and sequences end-of-test drain
module soc1_nios_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int DEPTH  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    atom_valid,
  input  logic [ATOM_W-1:0]       atom_code,
  output logic                    atom_ready,
  input  logic                    flush_req,
  input  logic                    test_end_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ATOM_W*DEPTH-1:0] out_word,
  output logic [CNT_W-1:0]        out_count,
  output logic [ATOM_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    test_ending,
  output logic                    test_has_ended
);
  localparam int BUF_W = ATOM_W * DEPTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  typedef enum logic [1:0] {RUN, END_FLUSH, ENDED} state_t;
  state_t state, state_nxt;
  logic flush_pend, out_free, accept, emit;
  assign out_free   = !out_valid | out_ready;
  assign atom_ready = reset_n & (state == RUN) & ((dct_count < FULL) | out_free);
  assign accept     = atom_valid & atom_ready;
  assign emit       = out_free & ((dct_count == FULL) |
                      ((flush_pend | state == END_FLUSH) & (dct_count != '0)));
  // end-of-test sequencing: leave RUN on request, finish once buffer and held word are drained
  always_comb begin
    state_nxt = (state == RUN && test_end_req) ? END_FLUSH :
                (state == END_FLUSH && dct_count == '0 && !out_valid) ? ENDED : state;
  end
  // state register with registered status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_nxt;
      test_ending    <= state_nxt != RUN;
      test_has_ended <= state_nxt == ENDED;
    end
  end
  // shift buffer, output word holding register and pending flush; an atom accepted on an emit edge starts the new buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      out_word   <= '0;
      out_count  <= '0;
      out_valid  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (emit) begin
        out_word  <= dct_buffer;
        out_count <= dct_count;
      end
      out_valid  <= emit | (out_valid & !out_ready);
      dct_buffer <= emit ? (accept ? BUF_W'(atom_code) : '0) :
                    accept ? {dct_buffer[BUF_W-ATOM_W-1:0], atom_code} : dct_buffer;
      dct_count  <= emit ? CNT_W'(accept) : dct_count + CNT_W'(accept);
      flush_pend <= (flush_req & (state == RUN)) | (flush_pend & !emit & (dct_count != '0));
    end
  end
endmodule

// File: tb/tb_soc1_nios_oci_dct_packer.sv
// tb_soc1_nios_oci_dct_packer: directed table, directed sequences and random stimulus against a queue-based model
module tb_soc1_nios_oci_dct_packer;
  logic clk = 1'b0;
  logic reset_n, atom_valid, flush_req, test_end_req, out_ready;
  logic [1:0] atom_code;
  logic atom_ready, out_valid, test_ending, test_has_ended;
  logic [29:0] out_word, dct_buffer;
  logic [3:0] out_count, dct_count;
  int vectors = 0, miscompares = 0;
  int mq[$];
  bit m_ov, m_fp;
  logic [29:0] m_word;
  int m_cnt, m_st;

  typedef struct {int av; int ac; int fr; int ov; int word; int ocnt; int bf; int dcnt;} vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  soc1_nios_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_code(atom_code),
    .atom_ready(atom_ready), .flush_req(flush_req), .test_end_req(test_end_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_count(out_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended)
  );

  function automatic vec_t mk(int av, int ac, int fr, int ov, int word, int ocnt, int bf, int dcnt);
    vec_t v;
    v.av = av; v.ac = ac; v.fr = fr; v.ov = ov; v.word = word; v.ocnt = ocnt; v.bf = bf; v.dcnt = dcnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // oldest atom sits in the most significant occupied pair
  function automatic logic [29:0] pack();
    longint w = 0;
    int n = mq.size();
    for (int i = 0; i < n; i++) w += longint'(mq[i]) * (longint'(1) << (2 * (n - 1 - i)));
    return 30'(w);
  endfunction

  task automatic do_reset();
    atom_valid = 0; flush_req = 0; test_end_req = 0; out_ready = 0;
    reset_n = 0;
    #1;
    chk("rst_atom_ready", 32'(atom_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_word", 32'(out_word), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_dct_buffer", 32'(dct_buffer), 0);
    chk("rst_dct_count", 32'(dct_count), 0);
    chk("rst_test_ending", 32'(test_ending), 0);
    chk("rst_test_has_ended", 32'(test_has_ended), 0);
    mq.delete(); m_ov = 0; m_fp = 0; m_word = '0; m_cnt = 0; m_st = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
  endtask

  task automatic step(input logic av, input logic [1:0] ac, input logic fr, input logic te, input logic ordy);
    int n;
    bit free, rdy, acc, emit;
    atom_valid = av; atom_code = ac; flush_req = fr; test_end_req = te; out_ready = ordy;
    n = mq.size();
    free = !m_ov || ordy;
    rdy = m_st == 0 && (n < 15 || free);
    acc = av && rdy;
    emit = free && (n == 15 || ((m_fp || m_st == 1) && n != 0));
    #1;
    chk("atom_ready", 32'(atom_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_word", 32'(out_word), 32'(m_word));
    chk("out_count", 32'(out_count), 32'(m_cnt));
    chk("dct_buffer", 32'(dct_buffer), 32'(pack()));
    chk("dct_count", 32'(dct_count), 32'(n));
    chk("test_ending", 32'(test_ending), 32'(m_st != 0));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_st == 2));
    m_fp = (fr && m_st == 0) || (m_fp && !emit && n != 0);
    if (m_st == 0 && te) m_st = 1;
    else if (m_st == 1 && n == 0 && !m_ov) m_st = 2;
    if (emit) begin
      m_word = pack(); m_cnt = n; mq.delete(); m_ov = 1;
    end else if (ordy) m_ov = 0;
    if (acc) mq.push_back(int'(ac));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    atom_valid = 0; atom_code = 0; flush_req = 0; test_end_req = 0; out_ready = 0; reset_n = 1;
    // three atoms then flush, empty flush, and a flush-driven emit coinciding with an accept
    tbl[0]  = mk(1, 3, 0, 0, 0,    0, 'h3,  1);
    tbl[1]  = mk(1, 2, 0, 0, 0,    0, 'he,  2);
    tbl[2]  = mk(1, 1, 0, 0, 0,    0, 'h39, 3);
    tbl[3]  = mk(0, 0, 1, 0, 0,    0, 'h39, 3);
    tbl[4]  = mk(0, 0, 0, 1, 'h39, 3, 0,    0);
    tbl[5]  = mk(0, 0, 0, 0, 'h39, 3, 0,    0);
    tbl[6]  = mk(0, 0, 1, 0, 'h39, 3, 0,    0);
    tbl[7]  = mk(0, 0, 0, 0, 'h39, 3, 0,    0);
    tbl[8]  = mk(0, 0, 0, 0, 'h39, 3, 0,    0);
    tbl[9]  = mk(1, 2, 0, 0, 'h39, 3, 'h2,  1);
    tbl[10] = mk(1, 1, 1, 0, 'h39, 3, 'h9,  2);
    tbl[11] = mk(1, 3, 0, 1, 'h9,  2, 'h3,  1);
    tbl[12] = mk(0, 0, 0, 0, 'h9,  2, 'h3,  1);
    #2;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      atom_valid = 1'(tbl[i].av); atom_code = 2'(tbl[i].ac); flush_req = 1'(tbl[i].fr);
      test_end_req = 0; out_ready = 1;
      #1 chk("tbl_atom_ready", 32'(atom_ready), 1);
      @(posedge clk); #1;
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      chk("tbl_out_word", 32'(out_word), 32'(tbl[i].word));
      chk("tbl_out_count", 32'(out_count), 32'(tbl[i].ocnt));
      chk("tbl_dct_buffer", 32'(dct_buffer), 32'(tbl[i].bf));
      chk("tbl_dct_count", 32'(dct_count), 32'(tbl[i].dcnt));
      @(negedge clk);
    end
    // full word with free downstream
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'((i + 1) % 4), 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_out_count_full", 32'(out_count), 15);
    step(0, 0, 0, 0, 1);
    // stalled downstream with a second word offered, reset while held, then a no-loss drain
    do_reset();
    for (int i = 0; i < 36; i++) step(1, 2'($urandom_range(3, 0)), 0, 0, 0);
    do_reset();
    for (int i = 0; i < 36; i++) step(1, 2'($urandom_range(3, 0)), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2'($urandom_range(3, 0)), 0, 0, 1);
    // end-of-test with a partial buffer and a stalled handshake
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 0, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 2'(i), 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 1, 1);
    chk("t5_has_ended", 32'(test_has_ended), 1);
    // reset mid-fill
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 2'(i), 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 2 && $urandom_range(19, 0) == 0) do_reset();
      step(1'($urandom_range(9, 0) < 7), 2'($urandom_range(3, 0)), 1'($urandom_range(9, 0) == 0),
           1'($urandom_range(199, 0) == 0), 1'($urandom_range(9, 0) < 6));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
